// File: rtl/lmd18245_pkg.sv
// Shared types and command encodings for the LMD18245 thermal monitor.
package lmd18245_pkg;

    localparam int CMD_W = 2;

    localparam logic [CMD_W-1:0] CMD_FWD       = 2'd0;
    localparam logic [CMD_W-1:0] CMD_REV       = 2'd1;
    localparam logic [CMD_W-1:0] CMD_BRAKE     = 2'd2;
    localparam logic [CMD_W-1:0] CMD_BRAKE_ALT = 2'd3;

    typedef enum logic [1:0] {
        ST_OK,
        ST_FAULT,
        ST_COOLDOWN,
        ST_HOLD
    } state_t;

endpackage

// File: rtl/lmd18245_flag_debounce.sv
// Synchronises an active-low driver status pin and debounces it into a
// level that only changes after DEBOUNCE_CYCLES consecutive stable samples.
module lmd18245_flag_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic flag_n,
    output logic active
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          hot_s;
    logic [CW-1:0] cnt;

    // Sync flops reset to the inactive (high) pin level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1  <= 1'b1;
            sync2  <= 1'b1;
            hot_s  <= 1'b0;
            cnt    <= '0;
            active <= 1'b0;
        end else begin
            sync1 <= flag_n;
            sync2 <= sync1;
            hot_s <= ~sync2;
            if (hot_s == active) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                active <= ~active;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/lmd18245_monitor.sv
// Thermal-fault monitor: forces brake on the LMD18245 command while the
// driver reports hot or is recovering, and counts fault episodes.
module lmd18245_monitor
    import lmd18245_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int COOLDOWN_CYCLES = 50_000_000,
    parameter int AUTO_RESTART    = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             thermal_flag_n,
    input  logic [CMD_W-1:0] cmd_in,
    input  logic             fault_clear,
    output logic [CMD_W-1:0] cmd_out,
    output logic             fault,
    output logic             overheat,
    output logic [7:0]       fault_count
);

    localparam int CCW = $clog2(COOLDOWN_CYCLES) + 1;
    localparam logic [CCW-1:0] COOL_LAST = CCW'(COOLDOWN_CYCLES - 1);

    state_t           state;
    state_t           nxt;
    logic [CCW-1:0]   cool_cnt;

    lmd18245_flag_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_flag (
        .clk   (clk),
        .reset (reset),
        .flag_n(thermal_flag_n),
        .active(overheat)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_OK;
        end else begin
            state <= nxt;
        end
    end

    // A rising overheat always wins over cool-down expiry or a clear.
    always_comb begin
        nxt = state;
        case (state)
            ST_OK: begin
                if (overheat) nxt = ST_FAULT;
            end
            ST_FAULT: begin
                if (!overheat) nxt = ST_COOLDOWN;
            end
            ST_COOLDOWN: begin
                if (overheat) begin
                    nxt = ST_FAULT;
                end else if (cool_cnt == '0) begin
                    nxt = (AUTO_RESTART != 0) ? ST_OK : ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (overheat) begin
                    nxt = ST_FAULT;
                end else if (fault_clear) begin
                    nxt = ST_OK;
                end
            end
            default: nxt = ST_OK;
        endcase
    end

    // Pass-through only while staying in OK, so brake is on the wire
    // the same edge a fault is entered and until one cycle after release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmd_out     <= CMD_BRAKE;
            cool_cnt    <= '0;
            fault_count <= '0;
        end else begin
            cmd_out <= (state == ST_OK && nxt == ST_OK) ? cmd_in : CMD_BRAKE;
            if (state == ST_OK && nxt == ST_FAULT && fault_count != 8'hFF) begin
                fault_count <= fault_count + 8'd1;
            end
            if (state == ST_FAULT && nxt == ST_COOLDOWN) begin
                cool_cnt <= COOL_LAST;
            end else if (state == ST_COOLDOWN && cool_cnt != '0) begin
                cool_cnt <= cool_cnt - CCW'(1);
            end
        end
    end

    assign fault = (state != ST_OK);

endmodule

// File: tb/tb_lmd18245_monitor.sv
// Bench for lmd18245_monitor: directed table, corner sequences and random
// pin activity checked against a history-based reference model.
module tb_lmd18245_monitor;

    localparam int D = 4;
    localparam int C = 10;

    localparam int M_OK    = 0;
    localparam int M_FAULT = 1;
    localparam int M_COOL  = 2;
    localparam int M_HOLD  = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       pin;
    logic [1:0] cmd_in;
    logic       clr;

    logic [1:0] cmd0, cmd1;
    logic       flt0, flt1;
    logic       ovh0, ovh1;
    logic [7:0] cnt0, cnt1;

    int vectors = 0;
    int miscompares = 0;

    lmd18245_monitor #(
        .DEBOUNCE_CYCLES(D),
        .COOLDOWN_CYCLES(C),
        .AUTO_RESTART   (0)
    ) dut0 (
        .clk           (clk),
        .reset         (reset),
        .thermal_flag_n(pin),
        .cmd_in        (cmd_in),
        .fault_clear   (clr),
        .cmd_out       (cmd0),
        .fault         (flt0),
        .overheat      (ovh0),
        .fault_count   (cnt0)
    );

    lmd18245_monitor #(
        .DEBOUNCE_CYCLES(D),
        .COOLDOWN_CYCLES(C),
        .AUTO_RESTART   (1)
    ) dut1 (
        .clk           (clk),
        .reset         (reset),
        .thermal_flag_n(pin),
        .cmd_in        (cmd_in),
        .fault_clear   (clr),
        .cmd_out       (cmd1),
        .fault         (flt1),
        .overheat      (ovh1),
        .fault_count   (cnt1)
    );

    always #5 clk = ~clk;

    // Reference model: overheat from a window over the pin history,
    // FSM from the stated state rules, cool-down as an end timestamp.
    bit         hist[$];
    bit         m_ovh;
    int         m_edge;
    int         m_mode[2];
    int         m_cool_end[2];
    int         m_count[2];
    logic [1:0] m_cmd[2];

    typedef struct {
        bit         pin;
        logic [1:0] cmd;
        bit         clr;
        int         n;
        logic [1:0] e_cmd;
        bit         e_fault;
        bit         e_ovh;
        logic [7:0] e_cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(bit p, logic [1:0] c, bit cl, int n,
                                logic [1:0] ec, bit ef, bit eo,
                                logic [7:0] ecnt);
        vec_t v;
        v.pin = p;
        v.cmd = c;
        v.clr = cl;
        v.n = n;
        v.e_cmd = ec;
        v.e_fault = ef;
        v.e_ovh = eo;
        v.e_cnt = ecnt;
        tbl.push_back(v);
    endfunction

    task automatic model_reset();
        hist.delete();
        m_ovh = 1'b0;
        m_edge = 0;
        for (int a = 0; a < 2; a++) begin
            m_mode[a] = M_OK;
            m_count[a] = 0;
            m_cmd[a] = 2'd2;
            m_cool_end[a] = 0;
        end
    endtask

    task automatic model_step();
        bit toggle;
        int idx;
        int nxt;
        m_edge++;
        for (int a = 0; a < 2; a++) begin
            nxt = m_mode[a];
            case (m_mode[a])
                M_OK: begin
                    if (m_ovh) begin
                        nxt = M_FAULT;
                        if (m_count[a] < 255) m_count[a]++;
                    end
                end
                M_FAULT: begin
                    if (!m_ovh) begin
                        nxt = M_COOL;
                        m_cool_end[a] = m_edge + C;
                    end
                end
                M_COOL: begin
                    if (m_ovh) nxt = M_FAULT;
                    else if (m_edge == m_cool_end[a])
                        nxt = (a == 1) ? M_OK : M_HOLD;
                end
                default: begin
                    if (m_ovh) nxt = M_FAULT;
                    else if (clr) nxt = M_OK;
                end
            endcase
            m_cmd[a] = (m_mode[a] == M_OK && nxt == M_OK) ? cmd_in : 2'd2;
            m_mode[a] = nxt;
        end
        hist.push_back(!pin);
        toggle = 1'b1;
        for (int j = 0; j < D; j++) begin
            idx = hist.size() - 4 - j;
            if (((idx >= 0) ? hist[idx] : 1'b0) == m_ovh) toggle = 1'b0;
        end
        if (toggle) m_ovh = !m_ovh;
        if (hist.size() > 32) void'(hist.pop_front());
    endtask

    task automatic chk(input string nm, input logic [1:0] ac,
                       input logic af, input logic ao, input logic [7:0] acnt,
                       input logic [1:0] ec, input logic ef, input logic eo,
                       input logic [7:0] ecnt);
        vectors++;
        if ({ac, af, ao, acnt} !== {ec, ef, eo, ecnt}) begin
            miscompares++;
            $display("FAIL %s @%0t: got cmd=%0d fault=%0b ovh=%0b cnt=%0d, want cmd=%0d fault=%0b ovh=%0b cnt=%0d",
                     nm, $time, ac, af, ao, acnt, ec, ef, eo, ecnt);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        model_step();
        chk("model_ar0", cmd0, flt0, ovh0, cnt0,
            m_cmd[0], m_mode[0] != M_OK, m_ovh, 8'(m_count[0]));
        chk("model_ar1", cmd1, flt1, ovh1, cnt1,
            m_cmd[1], m_mode[1] != M_OK, m_ovh, 8'(m_count[1]));
    endtask

    initial begin
        int len;
        reset = 1'b1;
        pin = 1'b1;
        cmd_in = 2'd0;
        clr = 1'b0;
        model_reset();

        add(1, 1, 0, 1,  1, 0, 0, 0);
        add(1, 0, 0, 1,  0, 0, 0, 0);
        add(0, 3, 0, 3,  3, 0, 0, 0);
        add(1, 3, 0, 8,  3, 0, 0, 0);
        add(0, 0, 0, 6,  0, 0, 0, 0);
        add(0, 0, 0, 1,  0, 0, 1, 0);
        add(0, 0, 0, 1,  2, 1, 1, 1);
        add(0, 0, 0, 5,  2, 1, 1, 1);
        add(1, 0, 0, 6,  2, 1, 1, 1);
        add(1, 0, 0, 1,  2, 1, 0, 1);
        add(1, 1, 1, 1,  2, 1, 0, 1);
        add(1, 1, 1, 9,  2, 1, 0, 1);
        add(1, 1, 0, 1,  2, 1, 0, 1);
        add(1, 1, 0, 5,  2, 1, 0, 1);
        add(1, 1, 1, 1,  2, 0, 0, 1);
        add(1, 1, 0, 1,  1, 0, 0, 1);
        add(0, 0, 0, 8,  2, 1, 1, 2);
        add(1, 0, 0, 8,  2, 1, 0, 2);
        add(0, 0, 0, 7,  2, 1, 1, 2);
        add(0, 0, 0, 1,  2, 1, 1, 2);
        add(0, 0, 0, 4,  2, 1, 1, 2);
        add(1, 0, 0, 17, 2, 1, 0, 2);
        add(1, 2, 0, 1,  2, 1, 0, 2);
        add(1, 1, 1, 1,  2, 0, 0, 2);
        add(1, 1, 0, 1,  1, 0, 0, 2);

        repeat (3) @(posedge clk);
        #1;
        chk("reset_ar0", cmd0, flt0, ovh0, cnt0, 2'd2, 1'b0, 1'b0, 8'd0);
        chk("reset_ar1", cmd1, flt1, ovh1, cnt1, 2'd2, 1'b0, 1'b0, 8'd0);
        reset = 1'b0;

        for (int r = 0; r < tbl.size(); r++) begin
            pin = tbl[r].pin;
            cmd_in = tbl[r].cmd;
            clr = tbl[r].clr;
            repeat (tbl[r].n) cycle();
            chk($sformatf("row%0d", r), cmd0, flt0, ovh0, cnt0,
                tbl[r].e_cmd, tbl[r].e_fault, tbl[r].e_ovh, tbl[r].e_cnt);
        end

        // Overheat returns on the very edge cool-down expires.
        pin = 1'b0;
        cmd_in = 2'd0;
        clr = 1'b0;
        repeat (8) cycle();
        pin = 1'b1;
        repeat (10) cycle();
        pin = 1'b0;
        repeat (7) cycle();
        cycle();
        chk("expiry_vs_refault", cmd1, flt1, ovh1, cnt1, 2'd2, 1'b1, 1'b1, 8'd3);
        pin = 1'b1;
        clr = 1'b1;
        repeat (30) cycle();
        clr = 1'b0;
        cycle();
        chk("recovered", cmd0, flt0, ovh0, cnt0, 2'd0, 1'b0, 1'b0, 8'd3);

        for (int r = 0; r < 200; r++) begin
            pin = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 25);
            for (int i = 0; i < len; i++) begin
                cmd_in = 2'($urandom_range(0, 3));
                clr = ($urandom_range(0, 7) == 0);
                cycle();
            end
        end

        for (int e = 0; e < 260; e++) begin
            pin = 1'b0;
            clr = 1'b0;
            repeat (8) cycle();
            pin = 1'b1;
            clr = 1'b1;
            repeat (20) cycle();
        end
        clr = 1'b0;
        cycle();
        chk("saturate_ar0", cmd0, flt0, ovh0, cnt0, cmd_in, 1'b0, 1'b0, 8'd255);
        chk("saturate_ar1", cmd1, flt1, ovh1, cnt1, cmd_in, 1'b0, 1'b0, 8'd255);

        // Reset mid-fault clears immediately; a still-hot pin re-faults
        // only after the full detect latency.
        pin = 1'b0;
        cmd_in = 2'd1;
        repeat (8) cycle();
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("async_reset", cmd0, flt0, ovh0, cnt0, 2'd2, 1'b0, 1'b0, 8'd0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (7) cycle();
        chk("refault_pre", cmd0, flt0, ovh0, cnt0, 2'd1, 1'b0, 1'b1, 8'd0);
        cycle();
        chk("refault_hit", cmd0, flt0, ovh0, cnt0, 2'd2, 1'b1, 1'b1, 8'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lmd18245_monitor.md
# lmd18245_monitor

Thermal-fault monitor for the LMD18245 H-bridge, handling the status path from driver back to controller. It synchronises and debounces the driver's active-low THERMAL FLAG pin and tracks fault, cool-down and hold states. It sits between the motion controller and the LMD18245 command decoder, passing the 2-bit motor command through unchanged when healthy and forcing brake (command 2) while a fault is active or recovering. It also counts fault occurrences for status readback.

## Interface
- DEBOUNCE_CYCLES, 1000: consecutive stable synchronised samples needed to change the debounced flag (≥1)
- COOLDOWN_CYCLES, 50_000_000: cycles the flag must stay clear before release (≥1)
- AUTO_RESTART, 0: 1 = return to OK after cool-down; 0 = wait in HOLD for fault_clear
- clk  in  1  system clock; one clock domain
- reset  in  1  asynchronous, active-high reset
- thermal_flag_n  in  1  raw THERMAL FLAG pin, active low, asynchronous to clk
- cmd_in  in  2  command from controller (0 fwd, 1 rev, 2/3 brake)
- fault_clear  in  1  single-cycle pulse; acknowledges fault in HOLD
- cmd_out  out  2  command to LMD18245 decoder, registered
- fault  out  1  high in FAULT, COOLDOWN, HOLD
- overheat  out  1  debounced flag (1 = driver reports hot)
- fault_count  out  8  number of OK→FAULT transitions, saturates at 255

## Operation
- Reset values: state OK, cmd_out=2, fault=0, overheat=0, fault_count=0, sync flops=1 (not hot), debounce counter 0, cooldown counter 0.
- Sync: 2-flop synchroniser on thermal_flag_n, inverted to hot_s.
- Debounce: counter runs while hot_s ≠ overheat. It clears to 0 when hot_s equals overheat. When it reaches DEBOUNCE_CYCLES, overheat toggles and the counter clears. Glitches shorter than DEBOUNCE_CYCLES are ignored.
- FSM states are OK, FAULT, COOLDOWN and HOLD.
  - OK: cmd_out <= cmd_in. If overheat=1, go to FAULT and increment fault_count (saturating).
  - FAULT: cmd_out <= 2. If overheat=0, go to COOLDOWN and load the cooldown counter with COOLDOWN_CYCLES-1.
  - COOLDOWN: cmd_out <= 2, counter decrements. If overheat=1, go back to FAULT with no count increment; this has priority over expiry. When the counter reaches 0, go to OK if AUTO_RESTART=1, else HOLD.
  - HOLD: cmd_out <= 2. If overheat=1, go to FAULT with no increment; this has priority over fault_clear. Otherwise fault_clear=1 sends the FSM to OK.
- fault_clear is ignored in OK, FAULT and COOLDOWN; it is not remembered.
- fault is decoded from the registered state, so it is glitch-free.
- Asynchronous reset mid-fault returns to OK immediately. The debounce restarts from not-hot, so a still-hot pin re-faults after the full detect latency.

## Timing
- Pass-through latency: cmd_in → cmd_out is 1 cycle in OK.
- Detect latency: the pin is first sampled low at edge N. hot_s goes high at N+2, overheat at N+1+DEBOUNCE_CYCLES+1, and the FSM is in FAULT with cmd_out=2 and fault=1 one edge later (N+DEBOUNCE_CYCLES+3).
- Clear latency: overheat falls with the same DEBOUNCE_CYCLES+2 pipeline. COOLDOWN then lasts exactly COOLDOWN_CYCLES cycles before OK or HOLD.
- HOLD → OK: the state is OK on the edge that samples fault_clear. cmd_out follows cmd_in on the next edge.
- Simultaneous overheat rise and counter expiry in COOLDOWN: FAULT wins.

## Structure
- Package lmd18245_pkg holds:
  - command constants CMD_FWD=2'd0, CMD_REV=2'd1, CMD_BRAKE=2'd2, CMD_BRAKE_ALT=2'd3;
  - the state typedef (OK, FAULT, COOLDOWN, HOLD);
  - the shared command width.
- Sub-module lmd18245_flag_debounce contains the synchroniser and debounce counter and outputs overheat. It is parameterised by DEBOUNCE_CYCLES and is reusable for other driver status pins.
- Counter widths are $clog2 of their parameters + 1.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, COOLDOWN_CYCLES=10, AUTO_RESTART=0 unless stated.
- Reset then healthy: after reset cmd_out=2. cmd_in=1 gives cmd_out=1 one cycle later, with fault=0 and fault_count=0.
- Glitch rejection: pin low for 3 cycles then high gives overheat=0, fault=0, and cmd_out still following cmd_in.
- Fault entry: pin held low from edge N. Required: fault=1, cmd_out=2 and fault_count=1 at N+7, and cmd_out stays 2 while cmd_in=0.
- Cool-down and hold: pin released, then COOLDOWN lasts 10 cycles and the FSM enters HOLD. A fault_clear during COOLDOWN is ignored. A fault_clear in HOLD gives fault=0 and cmd_out=cmd_in on the following cycle.
- Re-fault: the pin goes low again during COOLDOWN (after debounce) and returns the FSM to FAULT with fault_count still 1. A separate run with AUTO_RESTART=1 goes to OK with no clear.
- Saturation/reset: 256 fault episodes leave fault_count=255. Asserting reset mid-FAULT gives cmd_out=2, fault=0 and fault_count=0 immediately.
